instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 127 ++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding-request instruction fetch unit with redirect and flush.
// Define IF_ALIGN_CHECK_EN to trap misaligned redirect targets in a sticky FAULT state.
`timescale 1ns/1ps
module instr_fetch (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        inst_valid
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic        fetch_fault
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        FLUSH
`ifdef IF_ALIGN_CHECK_EN
        ,
        FAULT
`endif
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_flush_addr;
    logic [31:0] r_inst;
    logic [31:0] r_pc_out;
    logic        r_valid;
    logic [31:0] w_target;

`ifdef IF_ALIGN_CHECK_EN
    logic        r_fault;
    logic        w_bad_target;

    assign w_target     = redirect_pc;
    assign w_bad_target = |redirect_pc[1:0];
    assign fetch_fault  = r_fault;
`else
    logic        w_unused_lsb;

    // Without the alignment trap, targets are silently forced to word alignment.
    assign w_target     = {redirect_pc[31:2], 2'b00};
    assign w_unused_lsb = ^redirect_pc[1:0];
`endif

    // FLUSH keeps presenting the abandoned address until its response drains.
    assign imem_req   = (r_state == REQ) || (r_state == FLUSH);
    assign imem_addr  = (r_state == FLUSH) ? r_flush_addr : r_pc;
    assign inst_out   = r_inst;
    assign pc_out     = r_pc_out;
    assign inst_valid = r_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pc         <= 32'h0000_0000;
            r_flush_addr <= 32'h0000_0000;
            r_inst       <= 32'h0000_0000;
            r_pc_out     <= 32'h0000_0000;
            r_valid      <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            r_fault      <= 1'b0;
`endif
        end else
`ifdef IF_ALIGN_CHECK_EN
        if (r_state == FAULT) begin
            r_state <= FAULT;
        end else if (redirect_valid && w_bad_target) begin
            r_state <= FAULT;
            r_fault <= 1'b1;
            r_valid <= 1'b0;
        end else
`endif
        if (redirect_valid) begin
            r_pc    <= w_target;
            r_valid <= 1'b0;
            case (r_state)
                REQ: begin
                    if (!imem_ack) begin
                        r_flush_addr <= r_pc;
                        r_state      <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (imem_ack) r_state <= REQ;
                end
                default: r_state <= REQ;
            endcase
        end else begin
            case (r_state)
                IDLE: r_state <= REQ;
                REQ: begin
                    if (imem_ack) begin
                        r_inst   <= imem_rdata;
                        r_pc_out <= r_pc;
                        r_valid  <= 1'b1;
                        r_pc     <= r_pc + 32'd4;
                        r_state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        r_valid <= 1'b0;
                        r_state <= REQ;
                    end
                end
                FLUSH: begin
                    if (imem_ack) r_state <= REQ;
                end
                default: r_state <= r_state;
            endcase
        end
    end

endmodule
